lcd_driver: RTL and testbench



---
 rtl/lcd_pkg.sv | 36 +++
 rtl/lcd_timer.sv | 41 ++++
 rtl/lcd_driver.sv | 225 ++++++++++++++++++++++
 tb/tb_lcd_driver.sv | 243 ++++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lcd_pkg
// Description : Shared types and constants for the HD44780-style LCD driver.
// Revision    : 1.0 - initial release
// ============================================================================
package lcd_pkg;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        SETUP     = 3'd1,
        PULSE     = 3'd2,
        HOLD      = 3'd3,
        WAIT      = 3'd4,
        INIT_WAIT = 3'd5,
        INIT_CMD  = 3'd6
    } lcd_state_e;

    localparam int LCD_ON_BIT  = 31;
    localparam int LCD_RS_BIT  = 10;
    localparam int LCD_STB_BIT = 9;

    localparam int INIT_CMD_NUM = 4;
    localparam logic [0:INIT_CMD_NUM-1][7:0] INIT_CMDS = {8'h38, 8'h0C, 8'h01, 8'h06};

    // Clear (0x01) and return-home (0x02/0x03) need the long execution wait.
    function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
        return !rs && (data[7:2] == 6'd0) && (data != 8'd0);
    endfunction

    function automatic int max_int(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_timer.sv
`default_nettype none
// ============================================================================
// Module      : lcd_timer
// Description : Loadable down-counter shared by every timed LCD state.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_timer #(
    parameter int               CNT_W   = 8,
    parameter logic [CNT_W-1:0] RST_VAL = '0
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    output logic             o_done
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (i_load) begin
            count_d = i_load_val;
        end else if (count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            count_q <= RST_VAL;
        end else begin
            count_q <= count_d;
        end
    end

    assign o_done = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/lcd_driver.sv
`default_nettype none
// ============================================================================
// Module      : lcd_driver
// Description : Turns STB toggles on the LCD register into timed 8-bit LCD
//               write cycles. Define LCD_INIT_EN to run the power-on sequence.
// Revision    : 1.0 - initial release
// ============================================================================
module lcd_driver
    import lcd_pkg::*;
#(
    parameter int SETUP_CYC    = 4,
    parameter int EN_PULSE_CYC = 24,
    parameter int HOLD_CYC     = 4,
    parameter int CMD_WAIT_CYC = 2000,
    parameter int CLR_WAIT_CYC = 82000
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic [31:0] i_lcd_reg,
    output logic [7:0]  o_lcd_data,
    output logic        o_lcd_rs,
    output logic        o_lcd_rw,
    output logic        o_lcd_en,
    output logic        o_lcd_on,
    output logic        o_lcd_busy,
    output logic        o_lcd_ovf
);

`ifdef LCD_INIT_EN
    localparam int INIT_WAIT_CYC = CLR_WAIT_CYC * 10;
    localparam int MAX_CYC = max_int(max_int(CLR_WAIT_CYC, EN_PULSE_CYC), INIT_WAIT_CYC);
`else
    localparam int MAX_CYC = max_int(CLR_WAIT_CYC, EN_PULSE_CYC);
`endif
    localparam int CNT_W = $clog2(MAX_CYC + 1);

    localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(EN_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);
    localparam logic [CNT_W-1:0] CMD_LD   = CNT_W'(CMD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] CLR_LD   = CNT_W'(CLR_WAIT_CYC - 1);

`ifdef LCD_INIT_EN
    localparam logic [CNT_W-1:0] TMR_RST   = CNT_W'(INIT_WAIT_CYC - 1);
    localparam lcd_state_e       STATE_RST = INIT_WAIT;
`else
    localparam logic [CNT_W-1:0] TMR_RST   = '0;
    localparam lcd_state_e       STATE_RST = IDLE;
`endif

    if (SETUP_CYC < 1 || EN_PULSE_CYC < 1 || HOLD_CYC < 1 ||
        CMD_WAIT_CYC < 1 || CLR_WAIT_CYC < 1 ||
        SETUP_CYC > MAX_CYC || HOLD_CYC > MAX_CYC || CMD_WAIT_CYC > MAX_CYC) begin : g_bad_param
        $error("lcd_driver: timing parameters must be >= 1 and fit the timer");
    end

    lcd_state_e  state_q, state_d;
    logic        stb_prev_q;
    logic        pending_q, pending_d;
    logic        buf_rs_q, buf_rs_d;
    logic [7:0]  buf_data_q, buf_data_d;
    logic        ovf_q, ovf_d;
    logic        on_q;
    logic [7:0]  data_q, data_d;
    logic        rs_q, rs_d;
    logic        en_q, en_d;
`ifdef LCD_INIT_EN
    logic [2:0]  idx_q, idx_d;
`endif

    logic             w_req;
    logic             w_take;
    logic             w_tmr_load;
    logic [CNT_W-1:0] w_tmr_val;
    logic             w_tmr_done;
    logic             w_unused;

    assign w_unused = ^{i_lcd_reg[30:11], i_lcd_reg[8]};

    assign w_req  = (i_lcd_reg[LCD_STB_BIT] != stb_prev_q);
    assign w_take = (state_q == IDLE) && pending_q;

    // A request landing in the same cycle the buffer is drained becomes the
    // new pending entry without counting as an overwrite.
    always_comb begin
        pending_d  = pending_q;
        buf_rs_d   = buf_rs_q;
        buf_data_d = buf_data_q;
        ovf_d      = ovf_q;
        if (w_req) begin
            pending_d  = 1'b1;
            buf_rs_d   = i_lcd_reg[LCD_RS_BIT];
            buf_data_d = i_lcd_reg[7:0];
            if (pending_q && !w_take) begin
                ovf_d = 1'b1;
            end
        end else if (w_take) begin
            pending_d = 1'b0;
        end
    end

    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rs_d       = rs_q;
        w_tmr_load = 1'b0;
        w_tmr_val  = '0;
`ifdef LCD_INIT_EN
        idx_d      = idx_q;
`endif
        case (state_q)
            IDLE: begin
                if (pending_q) begin
                    data_d     = buf_data_q;
                    rs_d       = buf_rs_q;
                    state_d    = SETUP;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = SETUP_LD;
                end
            end
            SETUP: begin
                if (w_tmr_done) begin
                    state_d    = PULSE;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = PULSE_LD;
                end
            end
            PULSE: begin
                if (w_tmr_done) begin
                    state_d    = HOLD;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = HOLD_LD;
                end
            end
            HOLD: begin
                if (w_tmr_done) begin
                    state_d    = WAIT;
                    w_tmr_load = 1'b1;
                    w_tmr_val  = is_long_cmd(rs_q, data_q) ? CLR_LD : CMD_LD;
                end
            end
            WAIT: begin
                if (w_tmr_done) begin
`ifdef LCD_INIT_EN
                    state_d = (idx_q != 3'(INIT_CMD_NUM)) ? INIT_CMD : IDLE;
`else
                    state_d = IDLE;
`endif
                end
            end
`ifdef LCD_INIT_EN
            INIT_WAIT: begin
                if (w_tmr_done) begin
                    state_d = INIT_CMD;
                end
            end
            INIT_CMD: begin
                data_d     = INIT_CMDS[idx_q[1:0]];
                rs_d       = 1'b0;
                idx_d      = idx_q + 3'd1;
                state_d    = SETUP;
                w_tmr_load = 1'b1;
                w_tmr_val  = SETUP_LD;
            end
`endif
            default: begin
                state_d = IDLE;
            end
        endcase
        en_d = (state_d == PULSE);
    end

    lcd_timer #(
        .CNT_W   (CNT_W),
        .RST_VAL (TMR_RST)
    ) u_timer (
        .i_clk      (i_clk),
        .i_reset    (i_reset),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= STATE_RST;
            stb_prev_q <= 1'b0;
            pending_q  <= 1'b0;
            buf_rs_q   <= 1'b0;
            buf_data_q <= 8'd0;
            ovf_q      <= 1'b0;
            on_q       <= 1'b0;
            data_q     <= 8'd0;
            rs_q       <= 1'b0;
            en_q       <= 1'b0;
`ifdef LCD_INIT_EN
            idx_q      <= 3'd0;
`endif
        end else begin
            state_q    <= state_d;
            stb_prev_q <= i_lcd_reg[LCD_STB_BIT];
            pending_q  <= pending_d;
            buf_rs_q   <= buf_rs_d;
            buf_data_q <= buf_data_d;
            ovf_q      <= ovf_d;
            on_q       <= i_lcd_reg[LCD_ON_BIT];
            data_q     <= data_d;
            rs_q       <= rs_d;
            en_q       <= en_d;
`ifdef LCD_INIT_EN
            idx_q      <= idx_d;
`endif
        end
    end

    assign o_lcd_data = data_q;
    assign o_lcd_rs   = rs_q;
    assign o_lcd_rw   = 1'b0;
    assign o_lcd_en   = en_q;
    assign o_lcd_on   = on_q;
    assign o_lcd_busy = (state_q != IDLE) | pending_q;
    assign o_lcd_ovf  = ovf_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_driver.sv
`default_nettype none
// ============================================================================
// Module      : tb_lcd_driver
// Description : Directed self-checking bench for lcd_driver with a transfer
//               scoreboard; covers the LCD_INIT_EN sequence when defined.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_lcd_driver;

    localparam int SETUP = 2;
    localparam int PULSE = 4;
    localparam int HOLD  = 2;
    localparam int CMDW  = 10;
    localparam int CLRW  = 50;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] lcd_reg = 32'd0;
    logic [7:0]  o_lcd_data;
    logic        o_lcd_rs, o_lcd_rw, o_lcd_en, o_lcd_on, o_lcd_busy, o_lcd_ovf;

    int          vectors = 0;
    int          miscompares = 0;
    logic [8:0]  exp_q[$];
    logic        stb = 1'b0;
    logic        en_prev = 1'b0;
    int          en_cnt = 0;

    always #5 clk = ~clk;

    lcd_driver #(
        .SETUP_CYC    (SETUP),
        .EN_PULSE_CYC (PULSE),
        .HOLD_CYC     (HOLD),
        .CMD_WAIT_CYC (CMDW),
        .CLR_WAIT_CYC (CLRW)
    ) dut (
        .i_clk      (clk),
        .i_reset    (rst),
        .i_lcd_reg  (lcd_reg),
        .o_lcd_data (o_lcd_data),
        .o_lcd_rs   (o_lcd_rs),
        .o_lcd_rw   (o_lcd_rw),
        .o_lcd_en   (o_lcd_en),
        .o_lcd_on   (o_lcd_on),
        .o_lcd_busy (o_lcd_busy),
        .o_lcd_ovf  (o_lcd_ovf)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Each EN rising edge consumes one expected {RS,DATA}; each falling edge checks the width.
    always @(negedge clk) begin
        if (rst) begin
            en_prev <= 1'b0;
            en_cnt  <= 0;
        end else begin
            if (o_lcd_en && !en_prev) begin
                if (exp_q.size() == 0)
                    chk("sb_has_entry", 32'(exp_q.size()), 32'd1);
                else
                    chk("xfer_word", {23'd0, o_lcd_rs, o_lcd_data}, {23'd0, exp_q.pop_front()});
            end
            if (!o_lcd_en && en_prev)
                chk("en_width", 32'(en_cnt), 32'(PULSE));
            en_cnt  <= o_lcd_en ? en_cnt + 1 : 0;
            en_prev <= o_lcd_en;
        end
    end

    task automatic send(input logic on, input logic rs, input logic [7:0] d, input logic push);
        stb     = ~stb;
        lcd_reg = {on, 20'd0, rs, stb, 1'b0, d};
        if (push) exp_q.push_back({rs, d});
    endtask

    task automatic release_rst();
        rst = 1'b0;
`ifdef LCD_INIT_EN
        exp_q.push_back(9'h038);
        exp_q.push_back(9'h00C);
        exp_q.push_back(9'h001);
        exp_q.push_back(9'h006);
`endif
    endtask

    task automatic wait_idle(input int bound);
        int n = 0;
        while (o_lcd_busy && n < bound) begin
            @(negedge clk);
            n++;
        end
        chk("idle_timeout", 32'(o_lcd_busy), 32'd0);
    endtask

    task automatic xfer(input logic rs, input logic [7:0] d);
        int n = 0;
        int exp_len;
        logic long_cmd;
        long_cmd = !rs && (d[7:2] == 6'd0) && (d != 8'd0);
        exp_len  = 1 + SETUP + PULSE + HOLD + (long_cmd ? CLRW : CMDW);
        send(1'b1, rs, d, 1'b1);
        @(negedge clk);
        while (o_lcd_busy && n < 400) begin
            n++;
            @(negedge clk);
        end
        chk($sformatf("busy_len_%0d_%02h", rs, d), 32'(n), 32'(exp_len));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [8:0] tbl [7];
        tbl = '{9'h001, 9'h002, 9'h003, 9'h004, 9'h101, 9'h000, 9'h0FF};

        repeat (2) @(negedge clk);
        chk("reset_outs", {24'd0, o_lcd_en, o_lcd_busy, o_lcd_on, o_lcd_ovf,
                           o_lcd_rs, o_lcd_rw, 2'b00}, 32'd0);
        chk("reset_data", {24'd0, o_lcd_data}, 32'd0);
        release_rst();

`ifdef LCD_INIT_EN
        @(negedge clk);
        chk("init_busy", 32'(o_lcd_busy), 32'd1);
        repeat (9) @(negedge clk);
        send(1'b0, 1'b1, 8'hA5, 1'b1);
        repeat (491) @(negedge clk);
        chk("init_first_word", {23'd0, o_lcd_rs, o_lcd_data}, 32'h038);
        chk("init_en_low", 32'(o_lcd_en), 32'd0);
        @(negedge clk);
        chk("init_en_low2", 32'(o_lcd_en), 32'd0);
        @(negedge clk);
        chk("init_en_rise", 32'(o_lcd_en), 32'd1);
        wait_idle(2000);
`endif

        // First transfer, checked cycle by cycle
        repeat (2) @(negedge clk);
        chk("on_before", 32'(o_lcd_on), 32'd0);
        send(1'b1, 1'b0, 8'h41, 1'b1);
        @(negedge clk);
        chk("on_latency", 32'(o_lcd_on), 32'd1);
        chk("busy_pending", 32'(o_lcd_busy), 32'd1);
        @(negedge clk);
        chk("setup_word", {23'd0, o_lcd_rs, o_lcd_data}, 32'h041);
        chk("setup_en0", 32'(o_lcd_en), 32'd0);
        @(negedge clk);
        chk("setup_en1", 32'(o_lcd_en), 32'd0);
        @(negedge clk);
        chk("en_rise_t4", 32'(o_lcd_en), 32'd1);
        chk("rw_low", 32'(o_lcd_rw), 32'd0);
        repeat (15) @(negedge clk);
        chk("busy_t19", 32'(o_lcd_busy), 32'd1);
        @(negedge clk);
        chk("busy_t20", 32'(o_lcd_busy), 32'd0);

        // Execution wait length per command class
        for (int i = 0; i < 7; i++) begin
            xfer(tbl[i][8], tbl[i][7:0]);
            @(negedge clk);
        end

        // Request in the first IDLE cycle after a transfer
        send(1'b1, 1'b1, 8'h11, 1'b1);
        repeat (20) @(negedge clk);
        chk("idle_gap", 32'(o_lcd_busy), 32'd0);
        send(1'b1, 1'b1, 8'h22, 1'b1);
        @(negedge clk);
        chk("edge_pending", 32'(o_lcd_busy), 32'd1);
        chk("edge_no_ovf", 32'(o_lcd_ovf), 32'd0);
        wait_idle(200);
        chk("ovf_still_clear", 32'(o_lcd_ovf), 32'd0);

        // Two requests during one transfer: the second overwrites the first
        send(1'b1, 1'b1, 8'h55, 1'b1);
        repeat (5) @(negedge clk);
        send(1'b0, 1'b1, 8'h41, 1'b0);
        @(negedge clk);
        chk("single_pending_no_ovf", 32'(o_lcd_ovf), 32'd0);
        send(1'b0, 1'b1, 8'h42, 1'b1);
        @(negedge clk);
        chk("ovf_set", 32'(o_lcd_ovf), 32'd1);
        wait_idle(200);
        repeat (5) @(negedge clk);
        chk("ovf_sticky", 32'(o_lcd_ovf), 32'd1);

        // Reset while EN is high
        send(1'b1, 1'b0, 8'h30, 1'b1);
        repeat (4) @(negedge clk);
        chk("pre_reset_en", 32'(o_lcd_en), 32'd1);
        #2;
        rst     = 1'b1;
        stb     = 1'b0;
        lcd_reg = 32'd0;
        #1;
        chk("async_rst_en", 32'(o_lcd_en), 32'd0);
        chk("async_rst_busy", 32'(o_lcd_busy), 32'd0);
        chk("async_rst_data", {23'd0, o_lcd_rs, o_lcd_data}, 32'd0);
        chk("async_rst_ovf", 32'(o_lcd_ovf), 32'd0);
        @(negedge clk);
        @(negedge clk);
        release_rst();
`ifndef LCD_INIT_EN
        @(negedge clk);
        chk("no_req_after_rst", 32'(o_lcd_busy), 32'd0);
`endif
        repeat (30) @(negedge clk);
        wait_idle(2000);

        // STB left high across reset is seen as a request
        @(negedge clk);
        rst     = 1'b1;
        stb     = 1'b1;
        lcd_reg = 32'h0000_0263;
        @(negedge clk);
        @(negedge clk);
        release_rst();
        exp_q.push_back(9'h063);
        @(negedge clk);
        chk("stb_across_reset", 32'(o_lcd_busy), 32'd1);
        wait_idle(3000);

        repeat (5) @(negedge clk);
        chk("sb_drained", 32'(exp_q.size()), 32'd0);
        chk("final_ovf", 32'(o_lcd_ovf), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
